parity_frame_serializer: RTL and testbench

//   Upstream feeder for the serial even-parity checker FSM. Accepts a parallel word over a

---
 rtl/parity_frame_serializer.sv | 120 ++++++++++++
 tb/tb_parity_frame_serializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial frame source for the serial even-parity checker.
// Accepts a word over valid/ready and emits it LSB first. One even-parity bit follows the
// data. A one-cycle clear pulse precedes each frame, and a frame_done strobe follows it.
module parity_frame_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             par_clr,
  output logic             frame_done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             pbit;
  logic [BW-1:0]    bitcnt;
  logic [GW-1:0]    gapcnt;
  logic             accept;

  // Only din_ready sees reset combinationally; every other output decodes registered state.
  assign din_ready = (state == S_IDLE) && !reset;
  assign accept    = din_valid && din_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode
  always_comb begin
    state_nxt  = state;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    par_clr    = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = S_CLR;
      end
      S_CLR: begin
        par_clr   = 1'b1;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        ser_valid = 1'b1;
        ser_out   = shreg[0];
        if (bitcnt == BIT_LAST) state_nxt = S_PAR;
      end
      S_PAR: begin
        ser_valid = 1'b1;
        ser_out   = pbit;
        state_nxt = S_GAP;
      end
      S_GAP: begin
        frame_done = (gapcnt == '0);
        if (gapcnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, shift during DATA, count idle cycles during GAP
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      pbit   <= 1'b0;
      bitcnt <= '0;
      gapcnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg  <= din;
            pbit   <= ^din;
            bitcnt <= '0;
          end
        end
        S_DATA: begin
          shreg  <= shreg >> 1;
          bitcnt <= bitcnt + BW'(1);
        end
        S_PAR: begin
          gapcnt <= '0;
        end
        S_GAP: begin
          gapcnt <= gapcnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench for parity_frame_serializer: an 8-bit/GAP=1 instance and a 1-bit/GAP=3 instance.
module tb_parity_frame_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] din8;
  logic       valid8, rdy8, so8, sv8, clr8, fd8, busy8;
  logic [0:0] din1;
  logic       valid1, rdy1, so1, sv1, clr1, fd1, busy1;

  parity_frame_serializer #(.WIDTH(8), .GAP(1)) dut8 (
    .clk(clk), .reset(reset), .din(din8), .din_valid(valid8), .din_ready(rdy8),
    .ser_out(so8), .ser_valid(sv8), .par_clr(clr8), .frame_done(fd8), .busy(busy8)
  );

  parity_frame_serializer #(.WIDTH(1), .GAP(3)) dut1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(valid1), .din_ready(rdy1),
    .ser_out(so1), .ser_valid(sv1), .par_clr(clr1), .frame_done(fd1), .busy(busy1)
  );

  // Toggle-on-1 model of the downstream checker; its output reads ~odd8 (1 = even count).
  logic odd8;
  always_ff @(posedge clk) begin
    if (reset || clr8) odd8 <= 1'b0;
    else if (so8)      odd8 <= ~odd8;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 8-bit frame. Caller has din8/valid8 set in a cycle where the word will be accepted.
  // bits[i] is the i-th serial bit expected on the wire.
  task automatic run_frame8(input string name, input logic [7:0] bits, input logic par,
                            input logic hold_valid, input logic [7:0] next_din, input int poke);
    logic e_clr, e_sv, e_so, e_fd, e_busy, e_rdy;
    n_cmp++;
    if (rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, rdy8);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) begin
        din8 = next_din;
        if (!hold_valid) valid8 = 1'b0;
      end
      if (k == poke) begin
        din8   = 8'hFF;
        valid8 = 1'b1;
      end
      if (k == poke + 1 && !hold_valid) valid8 = 1'b0;
      e_clr = (k == 1);
      e_sv  = (k >= 2 && k <= 10);
      e_so  = (k >= 2 && k <= 9) ? bits[k-2] : (k == 10) ? par : 1'b0;
      e_fd  = (k == 11);
      e_busy = (k <= 11);
      e_rdy  = (k == 12);
      n_cmp += 6;
      if (clr8 !== e_clr) begin n_err++; $display("FAIL %s par_clr c%0d got=%b want=%b", name, k, clr8, e_clr); end
      if (sv8 !== e_sv) begin n_err++; $display("FAIL %s ser_valid c%0d got=%b want=%b", name, k, sv8, e_sv); end
      if (so8 !== e_so) begin n_err++; $display("FAIL %s ser_out c%0d got=%b want=%b", name, k, so8, e_so); end
      if (fd8 !== e_fd) begin n_err++; $display("FAIL %s frame_done c%0d got=%b want=%b", name, k, fd8, e_fd); end
      if (busy8 !== e_busy) begin n_err++; $display("FAIL %s busy c%0d got=%b want=%b", name, k, busy8, e_busy); end
      if (rdy8 !== e_rdy) begin n_err++; $display("FAIL %s din_ready c%0d got=%b want=%b", name, k, rdy8, e_rdy); end
      if (k == 11) begin
        n_cmp++;
        if (odd8 !== 1'b0) begin
          n_err++;
          $display("FAIL %s checker_out got=%b want=1", name, ~odd8);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; din8 = '0; valid8 = 1'b1; din1 = '0; valid1 = 1'b0;
    step(); step(); step();
    n_cmp += 6;
    if (rdy8 !== 1'b0) begin n_err++; $display("FAIL reset din_ready got=%b want=0", rdy8); end
    if (sv8 !== 1'b0) begin n_err++; $display("FAIL reset ser_valid got=%b want=0", sv8); end
    if (so8 !== 1'b0) begin n_err++; $display("FAIL reset ser_out got=%b want=0", so8); end
    if (clr8 !== 1'b0) begin n_err++; $display("FAIL reset par_clr got=%b want=0", clr8); end
    if (fd8 !== 1'b0) begin n_err++; $display("FAIL reset frame_done got=%b want=0", fd8); end
    if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset busy got=%b want=0", busy8); end
    valid8 = 1'b0;
    reset  = 1'b0;
    #1;
    n_cmp += 2;
    if (rdy8 !== 1'b1) begin n_err++; $display("FAIL reset_release din_ready8 got=%b want=1", rdy8); end
    if (rdy1 !== 1'b1) begin n_err++; $display("FAIL reset_release din_ready1 got=%b want=1", rdy1); end
  endtask

  task automatic test_a5();
    din8 = 8'hA5; valid8 = 1'b1;
    run_frame8("a5", 8'b1010_0101, 1'b0, 1'b0, 8'h00, 0);
  endtask

  task automatic test_single_one();
    din8 = 8'h01; valid8 = 1'b1;
    run_frame8("x01", 8'b0000_0001, 1'b1, 1'b0, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    din8 = 8'hFF; valid8 = 1'b1;
    run_frame8("b2b_ff", 8'b1111_1111, 1'b0, 1'b1, 8'h00, 0);
    run_frame8("b2b_00", 8'b0000_0000, 1'b0, 1'b0, 8'h00, 0);
  endtask

  task automatic test_ignore_busy();
    din8 = 8'h3C; valid8 = 1'b1;
    // serial order 0,0,1,1,1,1,0,0 written as bits[7:0]
    run_frame8("ignore", 8'b0011_1100, 1'b0, 1'b0, 8'h00, 3);
    valid8 = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int fd_seen;
    din8 = 8'hA5; valid8 = 1'b1;
    step();                       // cycle t+1
    valid8 = 1'b0;
    step(); step(); step();       // cycle t+4, inside DATA
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rdy8 !== 1'b0) begin n_err++; $display("FAIL midreset ready_in_reset got=%b want=0", rdy8); end
    step();                       // cycle t+5
    reset = 1'b0;
    #1;
    n_cmp += 4;
    if (sv8 !== 1'b0) begin n_err++; $display("FAIL midreset ser_valid got=%b want=0", sv8); end
    if (so8 !== 1'b0) begin n_err++; $display("FAIL midreset ser_out got=%b want=0", so8); end
    if (busy8 !== 1'b0) begin n_err++; $display("FAIL midreset busy got=%b want=0", busy8); end
    if (rdy8 !== 1'b1) begin n_err++; $display("FAIL midreset din_ready got=%b want=1", rdy8); end
    fd_seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (fd8 === 1'b1 || sv8 === 1'b1) fd_seen++;
      step();
    end
    n_cmp++;
    if (fd_seen !== 0) begin n_err++; $display("FAIL midreset stray_activity got=%0d want=0", fd_seen); end
  endtask

  task automatic test_width1_gap3();
    logic e_clr, e_sv, e_so, e_fd, e_rdy;
    din1 = 1'b1; valid1 = 1'b1;
    n_cmp++;
    if (rdy1 !== 1'b1) begin n_err++; $display("FAIL w1 ready_before got=%b want=1", rdy1); end
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) begin valid1 = 1'b0; din1 = 1'b0; end
      e_clr = (k == 1);
      e_sv  = (k == 2 || k == 3);
      e_so  = (k == 2 || k == 3);
      e_fd  = (k == 4);
      e_rdy = (k == 7);
      n_cmp += 6;
      if (clr1 !== e_clr) begin n_err++; $display("FAIL w1 par_clr c%0d got=%b want=%b", k, clr1, e_clr); end
      if (sv1 !== e_sv) begin n_err++; $display("FAIL w1 ser_valid c%0d got=%b want=%b", k, sv1, e_sv); end
      if (so1 !== e_so) begin n_err++; $display("FAIL w1 ser_out c%0d got=%b want=%b", k, so1, e_so); end
      if (fd1 !== e_fd) begin n_err++; $display("FAIL w1 frame_done c%0d got=%b want=%b", k, fd1, e_fd); end
      if (rdy1 !== e_rdy) begin n_err++; $display("FAIL w1 din_ready c%0d got=%b want=%b", k, rdy1, e_rdy); end
      if (busy1 !== !e_rdy) begin n_err++; $display("FAIL w1 busy c%0d got=%b want=%b", k, busy1, !e_rdy); end
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_single_one();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_busy();
    test_width1_gap3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
